debounce_edge_detect: RTL and testbench

//  Conditions one raw asynchronous input (push-button, external strobe) into a clean,

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_edge_detect_sync_chain.sv | 24 ++
 rtl/debounce_edge_detect.sv | 136 +++++++++++++
 tb/tb_debounce_edge_detect.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for debounce_edge_detect: FSM state encodings and glitch counter width.
package debounce_pkg;

    localparam logic [1:0] IDLE_LOW  = 2'b00;
    localparam logic [1:0] WAIT_HIGH = 2'b01;
    localparam logic [1:0] IDLE_HIGH = 2'b11;
    localparam logic [1:0] WAIT_LOW  = 2'b10;

    localparam int unsigned GLITCH_W = 8;

endpackage

// File: rtl/debounce_edge_detect_sync_chain.sv
// Multi-flop synchronizer (module sync_chain) with synchronous active-low reset to 0.
module sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain;

    always_ff @(posedge clk) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/debounce_edge_detect.sv
// Synchronizer + stable-count debounce FSM + registered rise/fall pulses.
// Optional DEBOUNCE_GLITCH_CNT_EN adds a saturating count of aborted transitions (glitch_cnt).
module debounce_edge_detect
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned STABLE_CNT  = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic                dout,
    output logic                rise_pulse,
    output logic                fall_pulse,
    output logic                busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync_q;
    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dout_nxt;
    logic             rise_nxt;
    logic             fall_nxt;
    logic             busy_nxt;

    sync_chain #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din),
        .q   (sync_q)
    );

    // State, counter and all outputs register together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            dout       <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dout       <= dout_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next state: a new level commits after STABLE_CNT identical samples of sync_q.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dout_nxt  = dout;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (sync_q) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    state_nxt = IDLE_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    dout_nxt  = 1'b1;
                    rise_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!sync_q) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end else begin
                    cnt_nxt = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    state_nxt = IDLE_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_LOW;
                    dout_nxt  = 1'b0;
                    fall_nxt  = 1'b1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                cnt_nxt   = '0;
                dout_nxt  = 1'b0;
            end
        endcase
        busy_nxt = (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
    end

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // Abort = WAIT state seeing the old level again; counter saturates.
    always_ff @(posedge clk) begin
        if (!rst) begin
            glitch_cnt <= '0;
        end else if (((state == WAIT_HIGH) && !sync_q) || ((state == WAIT_LOW) && sync_q)) begin
            if (glitch_cnt != '1) begin
                glitch_cnt <= glitch_cnt + GLITCH_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Directed self-checking bench for debounce_edge_detect (SYNC_STAGES=2, STABLE_CNT=4).
// Define DEBOUNCE_GLITCH_CNT_EN to also exercise glitch_cnt.
module tb_debounce_edge_detect;

    logic clk;
    logic rst;
    logic din;
    logic dout;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [7:0] glitch_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    debounce_edge_detect #(
        .SYNC_STAGES (2),
        .STABLE_CNT  (4),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt (glitch_cnt),
`endif
        .dout       (dout),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic d, input logic r,
                              input logic f, input logic b);
        check({tag, ".dout"}, 32'(dout), 32'(d));
        check({tag, ".rise"}, 32'(rise_pulse), 32'(r));
        check({tag, ".fall"}, 32'(fall_pulse), 32'(f));
        check({tag, ".busy"}, 32'(busy), 32'(b));
    endtask

    // Advance one rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_rise;
        logic seen_high;

        // Test 1: reset with din high, then release -> commit on the 6th edge.
        rst = 1'b0;
        din = 1'b1;
        repeat (3) step();
        check_outs("t1_reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t1_glitch", 32'(glitch_cnt), 32'd0);
`endif
        rst = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            step();
            check_outs($sformatf("t1_e%0d", e), e >= 6, e == 6, 1'b0, (e >= 3) && (e <= 5));
        end

        // Test 3: falling transition from dout=1.
        din = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            step();
            check_outs($sformatf("t3_e%0d", e), e < 6, 1'b0, e == 6, (e >= 3) && (e <= 5));
        end

        // Test 2: two-cycle glitch from dout=0 is aborted.
        for (int e = 1; e <= 8; e++) begin
            din = (e <= 2);
            step();
            check_outs($sformatf("t2_e%0d", e), 1'b0, 1'b0, 1'b0, (e == 3) || (e == 4));
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t2_glitch", 32'(glitch_cnt), 32'd1);
`endif

        // Test 4: reset while in WAIT_HIGH abandons the pending change.
        din = 1'b1;
        repeat (3) step();
        check("t4_busy_before", 32'(busy), 32'd1);
        rst = 1'b0;
        din = 1'b0;
        step();
        check_outs("t4_reset", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("t4_glitch", 32'(glitch_cnt), 32'd0);
`endif
        rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            check_outs($sformatf("t4_e%0d", e), 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Test 5: toggling input, then steady high -> exactly one rise.
        n_rise = 0;
        for (int i = 0; i < 10; i++) begin
            din = (i % 2 == 0);
            step();
            n_rise += int'(rise_pulse);
            check($sformatf("t5_tog%0d.dout", i), 32'(dout), 32'd0);
        end
        din = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_rise += int'(rise_pulse);
            check($sformatf("t5_e%0d.dout", e), 32'(dout), 32'(e >= 6));
            check($sformatf("t5_e%0d.rise", e), 32'(rise_pulse), 32'(e == 6));
        end
        check("t5_rise_count", 32'(n_rise), 32'd1);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // Test 6: 300 glitches saturate glitch_cnt; dout never moves.
        rst = 1'b0;
        din = 1'b0;
        step();
        rst = 1'b1;
        step();
        seen_high = 1'b0;
        for (int g = 0; g < 300; g++) begin
            for (int c = 0; c < 6; c++) begin
                din = (c < 2);
                step();
                if (dout || rise_pulse || fall_pulse) seen_high = 1'b1;
            end
            if (g == 0) check("t6_glitch_first", 32'(glitch_cnt), 32'd1);
            if (g == 9) check("t6_glitch_ten", 32'(glitch_cnt), 32'd10);
        end
        check("t6_glitch_sat", 32'(glitch_cnt), 32'hFF);
        check("t6_dout_quiet", 32'(seen_high), 32'd0);
`else
        seen_high = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
